multicycle_ctrl: RTL and testbench

- Moore control FSM that sequences the shared datapath of the multicycle RISC-V core: one ALU, one unified memory port, and the immediate extender.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives all mux selects and write enables, including the 2-bit ImmSrc select that configures the immediate extender.
- Supported instructions: lw, sw, R-type ALU (add/sub/and/or/slt), I-type ALU, beq, jal; bne when enabled.

---
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle datapath and its controller.
// master = datapath side (supplies instruction fields and ALU flag), slave = controller.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, instr_done, illegal, state
  );

  modport slave (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RISC-V datapath: sequences fetch,
// decode, execute, memory and writeback, driving every select and write enable.
module multicycle_ctrl #(
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state_q, state_d;
  logic [2:0] fn_ctl;
  logic       fn_bad;
  logic       branch_ok;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, done, ill;
  logic [1:0] result_src, src_a, src_b, imm_src;
  logic [2:0] alu_ctl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // ALU function from funct3; sub only for R-type (op[5]=1) with funct7b5 set
  always_comb begin
    fn_ctl = 3'b000;
    fn_bad = 1'b0;
    case (bus.funct3)
      3'b000:  fn_ctl = (bus.op[5] && bus.funct7b5) ? 3'b001 : 3'b000;
      3'b010:  fn_ctl = 3'b101;
      3'b110:  fn_ctl = 3'b011;
      3'b111:  fn_ctl = 3'b010;
      default: fn_bad = 1'b1;
    endcase
  end

  assign branch_ok = (bus.funct3 == 3'b000) || (SUPPORT_BNE && (bus.funct3 == 3'b001));

  always_comb begin
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = FETCH;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    ill        = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_ctl    = 3'b000;
    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        state_d    = DECODE;
      end
      DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_JAL:       state_d = JAL;
          OP_BR: begin
            if (branch_ok) state_d = BRANCH;
            else           ill     = 1'b1;
          end
          default:      ill = 1'b1;
        endcase
      end
      MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        done       = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        done      = 1'b1;
      end
      EXECR: begin
        src_a   = 2'b10;
        alu_ctl = fn_ctl;
        ill     = fn_bad;
        state_d = ALUWB;
      end
      EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_ctl = fn_ctl;
        ill     = fn_bad;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      BRANCH: begin
        src_a    = 2'b10;
        alu_ctl  = 3'b001;
        pc_write = (bus.funct3 == 3'b000) ? bus.zero : ~bus.zero;
        done     = 1'b1;
      end
      JAL: begin
        src_a    = 2'b01;
        src_b    = 2'b10;
        pc_write = 1'b1;
        state_d  = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset kills every enable at once, even mid-instruction; selects follow FETCH.
  assign bus.PCWrite    = pc_write  & ~rst;
  assign bus.IRWrite    = ir_write  & ~rst;
  assign bus.MemWrite   = mem_write & ~rst;
  assign bus.RegWrite   = reg_write & ~rst;
  assign bus.instr_done = done      & ~rst;
  assign bus.illegal    = ill       & ~rst;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = imm_src;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (bne enabled / disabled) checked
// cycle by cycle against per-state expected output vectors.
module tb_multicycle_ctrl;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
    S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6,
    S_EXECI = 4'd7, S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
    IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

  logic clk, clk_en, rst;
  multicycle_ctrl_if if0 ();
  multicycle_ctrl_if if1 ();

  multicycle_ctrl #(.SUPPORT_BNE(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  multicycle_ctrl #(.SUPPORT_BNE(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  logic [21:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk    = 1'b0;
    clk_en = 1'b1;
  end
  always #5 if (clk_en) clk = ~clk;

  // ---------------- reference model ----------------
  // Vector layout: state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
  // ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, instr_done, illegal.
  function automatic logic [21:0] exp_vec(logic [3:0] st, logic [6:0] op,
                                          logic [2:0] f3, logic f7, logic z, bit bne_en);
    logic pcw, adr, mw, irw, rw, dn, il;
    logic [1:0] rs, asa, asb, imm;
    logic [2:0] alu;
    {pcw, adr, mw, irw, rw, dn, il} = '0;
    {rs, asa, asb} = '0;
    alu = 3'b000;
    if (op == SW)      imm = 2'b01;
    else if (op == BR) imm = 2'b10;
    else if (op == JL) imm = 2'b11;
    else               imm = 2'b00;
    case (st)
      S_FETCH:    begin irw = 1; pcw = 1; asb = 2'b10; rs = 2'b10; end
      S_DECODE: begin
        asa = 2'b01; asb = 2'b01;
        if (op == BR) il = !(f3 == 3'b000 || (bne_en && f3 == 3'b001));
        else          il = !(op == LW || op == SW || op == RT || op == IT || op == JL);
      end
      S_MEMADR:   begin asa = 2'b10; asb = 2'b01; end
      S_MEMREAD:  adr = 1;
      S_MEMWB:    begin rs = 2'b01; rw = 1; dn = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; dn = 1; end
      S_EXECR, S_EXECI: begin
        asa = 2'b10;
        asb = (st == S_EXECI) ? 2'b01 : 2'b00;
        if (f3 == 3'b000)      alu = (op == RT && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) alu = 3'b101;
        else if (f3 == 3'b110) alu = 3'b011;
        else if (f3 == 3'b111) alu = 3'b010;
        else                   il  = 1;
      end
      S_ALUWB:    begin rw = 1; dn = 1; end
      S_BRANCH:   begin asa = 2'b10; alu = 3'b001; dn = 1; pcw = (f3 == 3'b000) ? z : !z; end
      S_JAL:      begin asa = 2'b01; asb = 2'b10; pcw = 1; end
      default:    il = 1;
    endcase
    return {st, pcw, adr, mw, irw, rs, asa, asb, alu, imm, rw, dn, il};
  endfunction

  task automatic push_expected(logic [6:0] op, logic [2:0] f3, logic f7, logic z, bit bne_en);
    logic [3:0] path[$];
    path.push_back(S_FETCH);
    path.push_back(S_DECODE);
    case (op)
      LW: begin path.push_back(S_MEMADR); path.push_back(S_MEMREAD); path.push_back(S_MEMWB); end
      SW: begin path.push_back(S_MEMADR); path.push_back(S_MEMWRITE); end
      RT: begin path.push_back(S_EXECR); path.push_back(S_ALUWB); end
      IT: begin path.push_back(S_EXECI); path.push_back(S_ALUWB); end
      JL: begin path.push_back(S_JAL); path.push_back(S_ALUWB); end
      BR: if (f3 == 3'b000 || (bne_en && f3 == 3'b001)) path.push_back(S_BRANCH);
      default: ;
    endcase
    foreach (path[i]) exp_q.push_back(exp_vec(path[i], op, f3, f7, z, bne_en));
  endtask

  function automatic logic [21:0] get_obs(bit sel);
    if (sel)
      return {if1.state, if1.PCWrite, if1.AdrSrc, if1.MemWrite, if1.IRWrite, if1.ResultSrc,
              if1.ALUSrcA, if1.ALUSrcB, if1.ALUControl, if1.ImmSrc, if1.RegWrite,
              if1.instr_done, if1.illegal};
    return {if0.state, if0.PCWrite, if0.AdrSrc, if0.MemWrite, if0.IRWrite, if0.ResultSrc,
            if0.ALUSrcA, if0.ALUSrcB, if0.ALUControl, if0.ImmSrc, if0.RegWrite,
            if0.instr_done, if0.illegal};
  endfunction

  // ---------------- driver ----------------
  // Called with clk low and the selected DUT in FETCH; leaves it the same way.
  task automatic run_instr(string name, bit sel, logic [6:0] op, logic [2:0] f3,
                           logic f7, logic z);
    logic [21:0] exp_v, obs;
    int cyc;
    if (sel) begin if1.op = op; if1.funct3 = f3; if1.funct7b5 = f7; if1.zero = z; end
    else     begin if0.op = op; if0.funct3 = f3; if0.funct7b5 = f7; if0.zero = z; end
    push_expected(op, f3, f7, z, !sel);
    cyc = 0;
    while (exp_q.size() > 0) begin
      if (cyc > 0) @(negedge clk);
      #1;
      exp_v = exp_q.pop_front();
      obs   = get_obs(sel);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, obs, exp_v);
      end
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    if0.op = 7'd0; if0.funct3 = 3'd0; if0.funct7b5 = 1'b0; if0.zero = 1'b0;
    if1.op = 7'd0; if1.funct3 = 3'd0; if1.funct7b5 = 1'b0; if1.zero = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({if0.state, if0.IRWrite, if0.PCWrite, if0.ALUSrcB} !== {4'd0, 1'b0, 1'b0, 2'b10}) begin
      n_fail++;
      $display("FAIL reset_hold: got st=%0d ir=%b pc=%b srcb=%b expected st=0 ir=0 pc=0 srcb=10",
               if0.state, if0.IRWrite, if0.PCWrite, if0.ALUSrcB);
    end
    rst = 1'b0;
    if0.op = LW;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (if0.state !== S_MEMREAD) begin
      n_fail++;
      $display("FAIL reset_pre_abort_state: got %0d expected %0d", if0.state, S_MEMREAD);
    end
    clk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({if0.state, if0.PCWrite, if0.IRWrite, if0.MemWrite, if0.RegWrite, if0.instr_done,
         if0.illegal} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_abort: got st=%0d en=%b expected st=0 en=000000", if0.state,
               {if0.PCWrite, if0.IRWrite, if0.MemWrite, if0.RegWrite, if0.instr_done, if0.illegal});
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({if0.state, if0.IRWrite, if0.PCWrite, if0.ALUSrcB} !== {4'd0, 1'b1, 1'b1, 2'b10}) begin
      n_fail++;
      $display("FAIL reset_release: got st=%0d ir=%b pc=%b srcb=%b expected st=0 ir=1 pc=1 srcb=10",
               if0.state, if0.IRWrite, if0.PCWrite, if0.ALUSrcB);
    end
    clk_en = 1'b1;
  endtask

  task automatic test_mem();
    run_instr("lw", 0, LW, 3'b010, 1'b0, 1'b0);
    run_instr("sw", 0, SW, 3'b010, 1'b1, 1'b1);
  endtask

  task automatic test_alu();
    run_instr("r_add", 0, RT, 3'b000, 1'b0, 1'b0);
    run_instr("r_sub", 0, RT, 3'b000, 1'b1, 1'b0);
    run_instr("r_slt", 0, RT, 3'b010, 1'b0, 1'b0);
    run_instr("r_or",  0, RT, 3'b110, 1'b0, 1'b0);
    run_instr("r_and", 0, RT, 3'b111, 1'b1, 1'b0);
    run_instr("r_bad_f3", 0, RT, 3'b001, 1'b0, 1'b0);
    run_instr("addi_f7", 0, IT, 3'b000, 1'b1, 1'b0);
    run_instr("slti", 0, IT, 3'b010, 1'b0, 1'b0);
    run_instr("andi", 0, IT, 3'b111, 1'b0, 1'b0);
    run_instr("i_bad_f3", 0, IT, 3'b101, 1'b1, 1'b0);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 0, BR, 3'b000, 1'b0, 1'b1);
    run_instr("beq_not",   0, BR, 3'b000, 1'b0, 1'b0);
    run_instr("bne_taken", 0, BR, 3'b001, 1'b0, 1'b0);
    run_instr("bne_not",   0, BR, 3'b001, 1'b0, 1'b1);
    run_instr("br_bad_f3", 0, BR, 3'b100, 1'b0, 1'b0);
  endtask

  task automatic test_jal_illegal();
    run_instr("jal", 0, JL, 3'b000, 1'b0, 1'b0);
    run_instr("op_bad", 0, BAD, 3'b000, 1'b0, 1'b0);
    run_instr("after_bad", 0, IT, 3'b110, 1'b0, 1'b0);
  endtask

  task automatic test_bne_disabled();
    @(negedge clk);
    do_reset();
    run_instr("nobne_bne", 1, BR, 3'b001, 1'b0, 1'b0);
    run_instr("nobne_beq", 1, BR, 3'b000, 1'b0, 1'b1);
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [6:0] op;
    logic [2:0] f3;
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 6))
        0: begin op = LW; f3 = 3'b010; end
        1: begin op = SW; f3 = 3'b010; end
        2: begin op = RT; f3 = 3'($urandom_range(0, 7)); end
        3: begin op = IT; f3 = 3'($urandom_range(0, 7)); end
        4: begin op = BR; f3 = 3'($urandom_range(0, 1)); end
        5: begin op = JL; f3 = 3'($urandom_range(0, 7)); end
        default: begin op = 7'($urandom_range(0, 127)); f3 = 3'($urandom_range(0, 7)); end
      endcase
      run_instr("b2b", 0, op, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_mem();
    test_alu();
    test_branch();
    test_jal_illegal();
    test_bne_disabled();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
